// File: rtl/bot_state_collector.sv
// Multi-bot state ingest: rescales each bot's (vx, vy, x, y) packet with saturation,
// gathers one packet per enabled bot per round and publishes a coherent snapshot.
module bot_state_collector #(
  parameter int NUM_BOTS    = 3,
  parameter int IN_W        = 32,
  parameter int IN_FRAC     = 16,
  parameter int OUT_W       = 16,
  parameter int OUT_FRAC    = 11,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BOTS-1:0]           bot_enable,
  input  logic [NUM_BOTS-1:0]           bot_valid,
  output logic [NUM_BOTS-1:0]           bot_ready,
  input  logic [NUM_BOTS*4*IN_W-1:0]    bot_data,
  output logic [NUM_BOTS*4*OUT_W-1:0]   snap_data,
  output logic [NUM_BOTS*4-1:0]         snap_sat,
  output logic [NUM_BOTS-1:0]           snap_stale,
  output logic                          snap_valid
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  localparam int TW    = $clog2(TIMEOUT_CYC);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]                   state;
  logic [TW-1:0]                tcnt;
  logic [NUM_BOTS-1:0]          fresh;
  logic [NUM_BOTS-1:0]          capture;
  logic [NUM_BOTS*4*OUT_W-1:0]  shadow_data;
  logic [NUM_BOTS*4-1:0]        shadow_sat;
  logic [NUM_BOTS*4*OUT_W-1:0]  conv_data;
  logic [NUM_BOTS*4-1:0]        conv_sat;
  logic [OUT_W:0]               cv;
  logic                         all_in;
  logic                         publish;

  // Returns {sat, word}; the value fits when all bits from OUT_W-1 upward agree.
  function automatic logic [OUT_W:0] convert(input logic [IN_W-1:0] w);
    logic signed [IN_W-1:0] sh;
    sh = $signed(w) >>> SHIFT;
    if ((&sh[IN_W-1:OUT_W-1]) || !(|sh[IN_W-1:OUT_W-1]))
      convert = {1'b0, sh[OUT_W-1:0]};
    else if (sh[IN_W-1])
      convert = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      convert = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    conv_data = '0;
    conv_sat  = '0;
    cv        = '0;
    for (int unsigned w = 0; w < NUM_BOTS*4; w++) begin
      cv = convert(bot_data[w*IN_W +: IN_W]);
      conv_data[w*OUT_W +: OUT_W] = cv[OUT_W-1:0];
      conv_sat[w] = cv[OUT_W];
    end
  end

  assign bot_ready = bot_enable & ~fresh;
  assign capture   = bot_valid & bot_ready;
  assign all_in    = (bot_enable != '0) && ((fresh & bot_enable) == bot_enable);
  assign publish   = (state == COLLECT) && (all_in || (tcnt == TW'(TIMEOUT_CYC - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      fresh       <= '0;
      shadow_data <= '0;
      shadow_sat  <= '0;
      snap_data   <= '0;
      snap_sat    <= '0;
      snap_stale  <= '0;
      snap_valid  <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      if (publish) begin
        for (int unsigned i = 0; i < NUM_BOTS; i++) begin
          if (fresh[i]) begin
            snap_data[i*4*OUT_W +: 4*OUT_W] <= shadow_data[i*4*OUT_W +: 4*OUT_W];
            snap_sat[i*4 +: 4]              <= shadow_sat[i*4 +: 4];
          end
        end
        snap_stale <= bot_enable & ~fresh;
        snap_valid <= 1'b1;
      end

      // Only non-fresh channels capture, so a capture on the publish edge never
      // overwrites shadow contents being published and opens the next round.
      for (int unsigned i = 0; i < NUM_BOTS; i++) begin
        if (capture[i]) begin
          shadow_data[i*4*OUT_W +: 4*OUT_W] <= conv_data[i*4*OUT_W +: 4*OUT_W];
          shadow_sat[i*4 +: 4]              <= conv_sat[i*4 +: 4];
        end
      end
      fresh <= (publish ? '0 : fresh) | capture;

      if (publish || (state == IDLE)) begin
        tcnt  <= '0;
        state <= (|capture) ? COLLECT : IDLE;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bot_state_collector.sv
// Self-checking bench for bot_state_collector: conversion table rounds plus
// hand-written timeout, overlap, enable-masking, throughput and reset sequences.
module tb_bot_state_collector;
  localparam int NB = 3;
  localparam int IW = 32;
  localparam int OW = 16;
  localparam int TO = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NB-1:0]         bot_enable;
  logic [NB-1:0]         bot_valid;
  logic [NB-1:0]         bot_ready;
  logic [NB*4*IW-1:0]    bot_data;
  logic [NB*4*OW-1:0]    snap_data;
  logic [NB*4-1:0]       snap_sat;
  logic [NB-1:0]         snap_stale;
  logic                  snap_valid;

  always #5 clk = ~clk;

  bot_state_collector #(
    .NUM_BOTS(NB), .IN_W(IW), .IN_FRAC(16), .OUT_W(OW), .OUT_FRAC(11), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bot_enable(bot_enable), .bot_valid(bot_valid),
    .bot_ready(bot_ready), .bot_data(bot_data), .snap_data(snap_data),
    .snap_sat(snap_sat), .snap_stale(snap_stale), .snap_valid(snap_valid)
  );

  typedef struct { logic [127:0] din; logic [63:0] dout; logic [3:0] sat; } vec_t;
  typedef struct { logic [191:0] data; logic [11:0] sat; logic [2:0] stale; int unsigned cyc; } pub_t;

  vec_t        tab [4];
  pub_t        sb [$];
  pub_t        mon_e;
  int unsigned checks = 0, errors = 0, cyc = 0, pubs_seen = 0;
  logic [191:0] m_snap = '0, m_pend = '0;
  logic [11:0]  m_sat = '0, m_pend_sat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pend(input int b, input int v);
    m_pend[b*64 +: 64]   = tab[v].dout;
    m_pend_sat[b*4 +: 4] = tab[v].sat;
  endtask

  task automatic push_pub(input logic [2:0] got, input logic [2:0] stale, input int unsigned c);
    pub_t e;
    for (int b = 0; b < NB; b++) begin
      if (got[b]) begin
        m_snap[b*64 +: 64] = m_pend[b*64 +: 64];
        m_sat[b*4 +: 4]    = m_pend_sat[b*4 +: 4];
      end
    end
    e.data = m_snap; e.sat = m_sat; e.stale = stale; e.cyc = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && snap_valid === 1'b1) begin
      pubs_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_snap_valid", 192'(snap_valid), '0);
      end else begin
        mon_e = sb.pop_front();
        chk("snap_data", snap_data, mon_e.data);
        chk("snap_sat", 192'(snap_sat), 192'(mon_e.sat));
        chk("snap_stale", 192'(snap_stale), 192'(mon_e.stale));
        chk("publish_cycle", 192'(cyc), 192'(mon_e.cyc));
      end
    end
  end

  // Bots 0,1,2 handshake on consecutive edges; publish one edge after bot 2.
  task automatic full_round(input int k);
    int unsigned e;
    logic [2:0]  got;
    e = 0;
    got = '0;
    for (int b = 0; b < NB; b++) begin
      bot_data[b*128 +: 128] = tab[(k+b)%4].din;
      bot_valid = '0;
      bot_valid[b] = 1'b1;
      chk($sformatf("ready_before_b%0d", b), 192'(bot_ready[b]), 192'(1));
      tick();
      e = cyc;
      load_pend(b, (k+b)%4);
      bot_valid = '0;
      got[b] = 1'b1;
      chk($sformatf("ready_low_after_b%0d", b), 192'(bot_ready & got), '0);
    end
    push_pub(3'b111, 3'b000, e + 1);
    tick();
    chk("ready_after_publish", 192'(bot_ready), 192'(3'b111));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 100000", $time);
    $fatal(1);
  end

  initial begin
    int unsigned e0, base;
    // words packed {y, x, vy, vx}
    tab[0] = '{din: {32'h0, 32'h0, 32'hFFFFC000, 32'h00018000}, dout: {16'h0, 16'h0, 16'hFE00, 16'h0C00}, sat: 4'b0000};
    tab[1] = '{din: {32'hFFEC0000, 32'h00140000, 32'h0, 32'h0}, dout: {16'h8000, 16'h7FFF, 16'h0, 16'h0}, sat: 4'b1100};
    tab[2] = '{din: {32'hFFEFFFFF, 32'hFFF00000, 32'h00100000, 32'h000FFFFF}, dout: {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF}, sat: 4'b1010};
    tab[3] = '{din: {32'h80000000, 32'h00000020, 32'h0000001F, 32'hFFFFFFFF}, dout: {16'h8000, 16'h0001, 16'h0000, 16'hFFFF}, sat: 4'b1000};

    rst_n = 1'b0;
    bot_enable = 3'b111;
    bot_valid = '0;
    bot_data = '0;
    #12;
    chk("reset_snap_data", snap_data, '0);
    chk("reset_snap_sat", 192'(snap_sat), '0);
    chk("reset_snap_stale", 192'(snap_stale), '0);
    chk("reset_snap_valid", 192'(snap_valid), '0);
    chk("reset_ready", 192'(bot_ready), 192'(3'b111));
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) full_round(k);

    // Timeout round of bots 0,1; bot 2 arrives on the publish edge and opens a new round.
    bot_data[0 +: 128] = tab[1].din;
    bot_valid = 3'b001;
    tick();
    e0 = cyc;
    load_pend(0, 1);
    bot_data[128 +: 128] = tab[3].din;
    bot_valid = 3'b010;
    tick();
    load_pend(1, 3);
    bot_valid = '0;
    push_pub(3'b011, 3'b100, e0 + TO);
    while (cyc < e0 + TO - 1) tick();
    bot_data[256 +: 128] = tab[1].din;
    bot_valid = 3'b100;
    tick();
    load_pend(2, 1);
    bot_valid = '0;
    chk("ready_after_overlap_publish", 192'(bot_ready), 192'(3'b011));
    push_pub(3'b100, 3'b011, e0 + 2*TO);
    while (cyc < e0 + 2*TO + 2) tick();

    // Dropping bot 2 mid-round completes the round.
    bot_data[0 +: 128] = tab[2].din;
    bot_valid = 3'b001;
    tick();
    load_pend(0, 2);
    bot_data[128 +: 128] = tab[0].din;
    bot_valid = 3'b010;
    tick();
    base = cyc;
    load_pend(1, 0);
    bot_valid = '0;
    bot_enable = 3'b011;
    push_pub(3'b011, 3'b000, base + 1);
    tick();
    tick();

    // Bot 2 disabled: it keeps valid high but is never accepted.
    bot_data[256 +: 128] = tab[0].din;
    chk("masked_ready2", 192'(bot_ready[2]), '0);
    bot_data[0 +: 128] = tab[3].din;
    bot_valid = 3'b101;
    tick();
    load_pend(0, 3);
    bot_data[128 +: 128] = tab[1].din;
    bot_valid = 3'b110;
    tick();
    base = cyc;
    load_pend(1, 1);
    bot_valid = 3'b100;
    push_pub(3'b011, 3'b000, base + 1);
    tick();
    tick();
    bot_valid = '0;

    // All disabled: no capture and no publish.
    bot_enable = '0;
    bot_valid = 3'b111;
    base = pubs_seen;
    repeat (2*TO) tick();
    chk("disabled_ready", 192'(bot_ready), '0);
    chk("disabled_no_publish", 192'(pubs_seen - base), '0);
    bot_valid = '0;
    bot_enable = 3'b111;
    tick();

    // Continuous valid: one round every two cycles.
    bot_valid = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < NB; b++) bot_data[b*128 +: 128] = tab[(r+1)%4].din;
      tick();
      base = cyc;
      for (int b = 0; b < NB; b++) load_pend(b, (r+1)%4);
      push_pub(3'b111, 3'b000, base + 1);
      if (r < 2) tick();
    end
    bot_valid = '0;
    tick();
    tick();

    // Reset mid-round discards the partial round.
    bot_data[0 +: 128] = tab[2].din;
    bot_valid = 3'b001;
    tick();
    bot_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    m_snap = '0;
    m_sat = '0;
    chk("midreset_snap_data", snap_data, '0);
    chk("midreset_snap_sat", 192'(snap_sat), '0);
    chk("midreset_snap_stale", 192'(snap_stale), '0);
    chk("midreset_snap_valid", 192'(snap_valid), '0);
    tick();
    chk("midreset_ready", 192'(bot_ready), 192'(3'b111));
    rst_n = 1'b1;
    base = pubs_seen;
    repeat (TO + 2) tick();
    chk("no_publish_after_reset", 192'(pubs_seen - base), '0);
    full_round(1);

    tick();
    chk("scoreboard_drained", 192'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
